// File: rtl/ultrasonic_proximity_filter.sv
// Sliding-window average of ultrasonic echo counts with hysteresis/debounce
// classification into a stable NEAR/FAR presence level and one-cycle edge events.
module ultrasonic_proximity_filter #(
  parameter int CNT_W       = 32,
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_CNT = 60000,
  parameter int NEAR_TH     = 100,
  parameter int FAR_TH      = 140,
  parameter int DEBOUNCE    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid_i,
  input  logic [CNT_W-1:0] echo_count_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] avg_o,
  output logic             avg_valid_o,
  output logic             near_o,
  output logic             near_rise_o,
  output logic             far_rise_o
);

  localparam int WIN   = 1 << AVG_LOG2;
  localparam int SUM_W = CNT_W + AVG_LOG2;
  localparam int DBC_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);

  localparam logic [CNT_W-1:0]  TIMEOUT_V = CNT_W'(TIMEOUT_CNT);
  localparam logic [CNT_W-1:0]  NEAR_V    = CNT_W'(NEAR_TH);
  localparam logic [CNT_W-1:0]  FAR_V     = CNT_W'(FAR_TH);
  localparam logic [AVG_LOG2:0] FILL_FULL = (AVG_LOG2 + 1)'(WIN);
  localparam logic [DBC_W-1:0]  DBC_DONE  = DBC_W'(DEBOUNCE);
  localparam logic [DBC_W-1:0]  DBC_ONE   = DBC_W'(1);

  typedef enum logic [1:0] {
    ST_FAR       = 2'd0,
    ST_ARMING    = 2'd1,
    ST_NEAR      = 2'd2,
    ST_RELEASING = 2'd3
  } state_t;

  logic [CNT_W-1:0]    win_q [WIN];
  logic [AVG_LOG2-1:0] wr_ptr_q;
  logic [AVG_LOG2:0]   fill_q, fill_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [CNT_W-1:0]    samp_d;
  logic [CNT_W-1:0]    avg_q;
  logic                avg_valid_q;

  state_t              state_q;
  logic [DBC_W-1:0]    dbc_q;
  logic                near_q, near_rise_q, far_rise_q;
  logic                near_hit_s, far_hit_s;

  // Clamped sample and the running-sum update; unwritten slots hold 0, so the
  // oldest value subtracted while filling is naturally 0.
  always_comb begin
    samp_d = (echo_count_i >= TIMEOUT_V) ? TIMEOUT_V : echo_count_i;
    sum_d  = sum_q + SUM_W'(samp_d) - SUM_W'(win_q[wr_ptr_q]);
    if (fill_q == FILL_FULL) begin
      fill_d = fill_q;
    end else begin
      fill_d = fill_q + (AVG_LOG2 + 1)'(1);
    end
  end

  // Window buffer, running sum and the registered average.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      for (int i = 0; i < WIN; i++) win_q[i] <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      sum_q       <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else if (sample_valid_i) begin
      win_q[wr_ptr_q] <= samp_d;
      wr_ptr_q        <= wr_ptr_q + AVG_LOG2'(1);
      fill_q          <= fill_d;
      sum_q           <= sum_d;
      avg_q           <= CNT_W'(sum_d >> AVG_LOG2);
      avg_valid_q     <= (fill_d == FILL_FULL);
    end else begin
      avg_valid_q <= 1'b0;
    end
  end

  assign near_hit_s = (avg_q < NEAR_V);
  assign far_hit_s  = (avg_q >= FAR_V);

  // Hysteresis/debounce FSM, stepped once per valid average.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      state_q     <= ST_FAR;
      dbc_q       <= '0;
      near_q      <= 1'b0;
      near_rise_q <= 1'b0;
      far_rise_q  <= 1'b0;
    end else begin
      near_rise_q <= 1'b0;
      far_rise_q  <= 1'b0;
      if (avg_valid_q) begin
        case (state_q)
          ST_FAR: begin
            if (near_hit_s && (DBC_ONE == DBC_DONE)) begin
              state_q <= ST_NEAR; dbc_q <= '0; near_q <= 1'b1; near_rise_q <= 1'b1;
            end else if (near_hit_s) begin
              state_q <= ST_ARMING; dbc_q <= DBC_ONE;
            end else begin
              dbc_q <= '0;
            end
          end
          ST_ARMING: begin
            if (near_hit_s && (dbc_q + DBC_ONE == DBC_DONE)) begin
              state_q <= ST_NEAR; dbc_q <= '0; near_q <= 1'b1; near_rise_q <= 1'b1;
            end else if (near_hit_s) begin
              dbc_q <= dbc_q + DBC_ONE;
            end else begin
              state_q <= ST_FAR; dbc_q <= '0;
            end
          end
          ST_NEAR: begin
            if (far_hit_s && (DBC_ONE == DBC_DONE)) begin
              state_q <= ST_FAR; dbc_q <= '0; near_q <= 1'b0; far_rise_q <= 1'b1;
            end else if (far_hit_s) begin
              state_q <= ST_RELEASING; dbc_q <= DBC_ONE;
            end else begin
              dbc_q <= '0;
            end
          end
          ST_RELEASING: begin
            if (far_hit_s && (dbc_q + DBC_ONE == DBC_DONE)) begin
              state_q <= ST_FAR; dbc_q <= '0; near_q <= 1'b0; far_rise_q <= 1'b1;
            end else if (far_hit_s) begin
              dbc_q <= dbc_q + DBC_ONE;
            end else begin
              state_q <= ST_NEAR; dbc_q <= '0;
            end
          end
          default: begin
            state_q <= ST_FAR; dbc_q <= '0; near_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign avg_o       = avg_q;
  assign avg_valid_o = avg_valid_q;
  assign near_o      = near_q;
  assign near_rise_o = near_rise_q;
  assign far_rise_o  = far_rise_q;

endmodule

// File: tb/tb_ultrasonic_proximity_filter.sv
// Randomized self-checking bench for ultrasonic_proximity_filter against a
// queue-based window average and a run-length hysteresis model.
module tb_ultrasonic_proximity_filter;

  localparam int CNT_W = 32, AVG_LOG2 = 2, WIN = 4;
  localparam longint TIMEOUT_CNT = 60000, NEAR_TH = 100, FAR_TH = 140;
  localparam int DEBOUNCE = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             sample_valid_i;
  logic [CNT_W-1:0] echo_count_i;
  logic             flush_i;
  logic [CNT_W-1:0] avg_o;
  logic             avg_valid_o, near_o, near_rise_o, far_rise_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  longint    m_win[$];
  logic [31:0] m_avg;
  bit        m_av, m_near, m_nr, m_fr;
  int        m_run;

  ultrasonic_proximity_filter dut (
    .clk(clk), .rst(rst), .sample_valid_i(sample_valid_i), .echo_count_i(echo_count_i),
    .flush_i(flush_i), .avg_o(avg_o), .avg_valid_o(avg_valid_o), .near_o(near_o),
    .near_rise_o(near_rise_o), .far_rise_o(far_rise_o)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs, let the edge pass, then advance the model.
  task automatic step(input bit r, input bit v, input logic [31:0] d, input bit f);
    longint s, sum;
    @(negedge clk);
    rst = r; sample_valid_i = v; echo_count_i = d; flush_i = f;
    @(posedge clk);
    #1;
    m_nr = 0; m_fr = 0;
    if (r || f) begin
      m_near = 0; m_run = 0;
    end else if (m_av) begin
      if (!m_near) begin
        if (m_avg < NEAR_TH) begin
          m_run++;
          if (m_run == DEBOUNCE) begin m_near = 1; m_nr = 1; m_run = 0; end
        end else m_run = 0;
      end else begin
        if (m_avg >= FAR_TH) begin
          m_run++;
          if (m_run == DEBOUNCE) begin m_near = 0; m_fr = 1; m_run = 0; end
        end else m_run = 0;
      end
    end
    if (r || f) begin
      m_win.delete(); m_avg = 0; m_av = 0;
    end else if (v) begin
      s = (longint'(d) >= TIMEOUT_CNT) ? TIMEOUT_CNT : longint'(d);
      m_win.push_back(s);
      if (m_win.size() > WIN) void'(m_win.pop_front());
      sum = 0;
      foreach (m_win[i]) sum += m_win[i];
      m_avg = 32'(sum / WIN);
      m_av  = (m_win.size() == WIN);
    end else begin
      m_av = 0;
    end
  endtask

  task automatic test_reset();
    step(1, 1, 32'd50, 0);
    step(1, 1, 32'd70, 0);
    checks++;
    if ({avg_o, avg_valid_o, near_o, near_rise_o, far_rise_o} !== {32'd0, 4'b0000}) begin
      errors++;
      $display("FAIL reset: got avg=%0d av=%0b near=%0b nr=%0b fr=%0b, want all 0",
               avg_o, avg_valid_o, near_o, near_rise_o, far_rise_o);
    end
    step(0, 0, 32'd0, 0);
  endtask

  task automatic test_fill_near();
    int first_av = -1, rise_at = -1;
    for (int i = 0; i < 9; i++) begin
      step(0, (i < 6), 32'd50, 0);
      if (avg_valid_o && first_av < 0) first_av = i;
      if (near_rise_o) rise_at = i;
      checks++;
      if ({avg_o, avg_valid_o, near_o, near_rise_o, far_rise_o} !== {m_avg, m_av, m_near, m_nr, m_fr}) begin
        errors++;
        $display("FAIL fill_near cyc%0d: got avg=%0d av=%0b near=%0b nr=%0b fr=%0b, want %0d %0b %0b %0b %0b",
                 i, avg_o, avg_valid_o, near_o, near_rise_o, far_rise_o, m_avg, m_av, m_near, m_nr, m_fr);
      end
    end
    checks++;
    if (first_av !== 3 || rise_at !== 6) begin
      errors++;
      $display("FAIL fill_near_timing: got first_av=%0d rise=%0d, want 3 and 6", first_av, rise_at);
    end
  endtask

  task automatic test_hold_release();
    int fr_cnt = 0;
    for (int i = 0; i < 18; i++) begin
      step(0, 1, (i < 10) ? 32'd120 : 32'd200, 0);
      if (far_rise_o) fr_cnt++;
      checks++;
      if ({avg_o, avg_valid_o, near_o, near_rise_o, far_rise_o} !== {m_avg, m_av, m_near, m_nr, m_fr}) begin
        errors++;
        $display("FAIL hold_release cyc%0d: got avg=%0d av=%0b near=%0b nr=%0b fr=%0b, want %0d %0b %0b %0b %0b",
                 i, avg_o, avg_valid_o, near_o, near_rise_o, far_rise_o, m_avg, m_av, m_near, m_nr, m_fr);
      end
    end
    checks++;
    if (fr_cnt !== 1 || near_o !== 1'b0) begin
      errors++;
      $display("FAIL hold_release_edge: got far_rise count=%0d near=%0b, want 1 and 0", fr_cnt, near_o);
    end
  endtask

  task automatic test_clamp();
    step(0, 0, 32'd0, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, (i < 4), 32'hFFFF_FFFF, 0);
      checks++;
      if ({avg_o, avg_valid_o, near_o, near_rise_o, far_rise_o} !== {m_avg, m_av, m_near, m_nr, m_fr}) begin
        errors++;
        $display("FAIL clamp cyc%0d: got avg=%0d av=%0b near=%0b, want %0d %0b %0b",
                 i, avg_o, avg_valid_o, near_o, m_avg, m_av, m_near);
      end
    end
    checks++;
    if (avg_o !== 32'd60000) begin
      errors++;
      $display("FAIL clamp_value: got avg=%0d, want 60000", avg_o);
    end
  endtask

  task automatic test_abort();
    int nr_cnt = 0;
    logic [31:0] seq [16];
    seq = '{32'd50, 32'd50, 32'd50, 32'd50, 32'd50, 32'd450, 32'd50, 32'd50,
            32'd100, 32'd100, 32'd100, 32'd100, 32'd100, 32'd100, 32'd100, 32'd100};
    step(0, 0, 32'd0, 1);
    for (int i = 0; i < 18; i++) begin
      step(0, (i < 16), (i < 16) ? seq[i] : 32'd0, 0);
      if (near_rise_o) nr_cnt++;
      checks++;
      if ({avg_o, avg_valid_o, near_o, near_rise_o, far_rise_o} !== {m_avg, m_av, m_near, m_nr, m_fr}) begin
        errors++;
        $display("FAIL abort cyc%0d: got avg=%0d av=%0b near=%0b nr=%0b, want %0d %0b %0b %0b",
                 i, avg_o, avg_valid_o, near_o, near_rise_o, m_avg, m_av, m_near, m_nr);
      end
    end
    checks++;
    if (nr_cnt !== 0) begin
      errors++;
      $display("FAIL abort_no_rise: got %0d near_rise pulses, want 0", nr_cnt);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 8; i++) step(0, 1, 32'd40, 0);
    checks++;
    if (near_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre: got near=%0b, want 1", near_o);
    end
    step(0, 1, 32'd40, 1);
    checks++;
    if ({avg_o, avg_valid_o, near_o, near_rise_o, far_rise_o} !== {32'd0, 4'b0000}) begin
      errors++;
      $display("FAIL flush_clear: got avg=%0d av=%0b near=%0b nr=%0b fr=%0b, want all 0",
               avg_o, avg_valid_o, near_o, near_rise_o, far_rise_o);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 32'd40, 0);
      checks++;
      if (avg_valid_o !== (i == 3) || far_rise_o !== 1'b0 || avg_o !== m_avg) begin
        errors++;
        $display("FAIL flush_refill%0d: got av=%0b fr=%0b avg=%0d, want %0b 0 %0d",
                 i, avg_valid_o, far_rise_o, avg_o, (i == 3), m_avg);
      end
    end
  endtask

  task automatic test_random(input int n, input bit back_to_back);
    logic [31:0] d;
    bit v, f;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 9))
        0:       d = $urandom;
        1, 2:    d = 32'($urandom_range(95, 145));
        3, 4, 5: d = 32'($urandom_range(0, 99));
        default: d = 32'($urandom_range(140, 300));
      endcase
      v = back_to_back ? 1'b1 : ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 79) == 0);
      step(0, v, d, f);
      checks++;
      if ({avg_o, avg_valid_o, near_o, near_rise_o, far_rise_o} !== {m_avg, m_av, m_near, m_nr, m_fr}
          || (near_rise_o && far_rise_o)) begin
        errors++;
        $display("FAIL random cyc%0d: got avg=%0d av=%0b near=%0b nr=%0b fr=%0b, want %0d %0b %0b %0b %0b",
                 i, avg_o, avg_valid_o, near_o, near_rise_o, far_rise_o, m_avg, m_av, m_near, m_nr, m_fr);
      end
    end
  endtask

  initial begin
    rst = 1'b1; sample_valid_i = 1'b0; echo_count_i = 32'd0; flush_i = 1'b0;
    m_avg = 32'd0; m_av = 0; m_near = 0; m_nr = 0; m_fr = 0; m_run = 0;
    test_reset();
    test_fill_near();
    test_hold_release();
    test_clamp();
    test_abort();
    test_flush();
    test_random(400, 1'b0);
    test_random(200, 1'b1);
    step(1, 0, 32'd0, 0);
    checks++;
    if ({avg_o, avg_valid_o, near_o, near_rise_o, far_rise_o} !== {32'd0, 4'b0000}) begin
      errors++;
      $display("FAIL final_reset: got avg=%0d av=%0b near=%0b, want 0 0 0", avg_o, avg_valid_o, near_o);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
